// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluation: clears and fills a 32-byte secondary OAM during dots 1-256,
// then presents one secondary-OAM slot per 8-dot fetch window during dots 257-320.
module sprite_eval (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  cycle,
  input  logic [8:0]  scanline,
  input  logic        rendering,
  input  logic        sp_size16,
  input  logic        sp_pt_sel,
  output logic [7:0]  oam_addr,
  input  logic [7:0]  oam_data,
  output logic [7:0]  sp_tile,
  output logic [7:0]  sp_at,
  output logic [7:0]  sp_x,
  output logic [12:0] sp_pat_addr,
  output logic        sp_inscan,
  output logic        sp0_in_line,
  output logic        overflow
);

  typedef enum logic [2:0] {StIdle, StClear, StScanY, StCopy, StOvfScan, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  wp_q, wp_d;
  logic [5:0]  n_q, n_d;
  logic [1:0]  bc_q, bc_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic        ovf_q, ovf_d;
  logic        sp0_next_q, sp0_next_d;
  logic        sp0_line_q, sp0_line_d;
  logic [7:0]  sec_q [32];

  logic        sec_we;
  logic [4:0]  sec_wa;
  logic [7:0]  sec_wd;

  logic        active;
  logic        even;
  logic [8:0]  diff;
  logic        in_range;
  logic [5:0]  n_inc;
  logic [5:0]  wp_inc;

  assign active   = rendering && (scanline <= 9'd239);
  assign even     = ~cycle[0];
  assign diff     = scanline - {1'b0, oam_data};
  assign in_range = diff < (sp_size16 ? 9'd16 : 9'd8);
  assign n_inc    = n_q + 6'd1;
  assign wp_inc   = wp_q + 6'd1;

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    n_d        = n_q;
    bc_d       = bc_q;
    oam_addr_d = oam_addr_q;
    ovf_d      = ovf_q;
    sp0_next_d = sp0_next_q;
    sp0_line_d = sp0_line_q;
    sec_we     = 1'b0;
    sec_wa     = wp_q[4:0];
    sec_wd     = oam_data;

    if (cycle == 9'd257) begin
      sp0_line_d = sp0_next_q;
      sp0_next_d = 1'b0;
    end
    if (scanline == 9'd261 && cycle == 9'd1) begin
      ovf_d = 1'b0;
    end

    if (!active) begin
      state_d = StIdle;
    end else if (cycle >= 9'd1 && cycle <= 9'd64) begin
      state_d = StClear;
      if (even) begin
        // (cycle - 1) >> 1 for even cycles in 2..64
        sec_we = 1'b1;
        sec_wa = cycle[5:1] - 5'd1;
        sec_wd = 8'hFF;
      end
      if (cycle == 9'd64) begin
        wp_d       = 6'd0;
        n_d        = 6'd0;
        oam_addr_d = 8'd0;
        state_d    = StScanY;
      end
    end else if (cycle >= 9'd65 && cycle <= 9'd256) begin
      // Odd dots only present oam_addr; all work happens when data returns on even dots.
      if (even) begin
        unique case (state_q)
          StScanY: begin
            sec_we = 1'b1;
            if (in_range) begin
              wp_d       = wp_inc;
              bc_d       = 2'd1;
              oam_addr_d = {n_q, 2'b01};
              state_d    = StCopy;
              if (n_q == 6'd0) sp0_next_d = 1'b1;
            end else begin
              n_d        = n_inc;
              oam_addr_d = {n_inc, 2'b00};
              if (n_q == 6'd63) state_d = StDone;
            end
          end
          StCopy: begin
            sec_we = 1'b1;
            wp_d   = wp_inc;
            if (bc_q == 2'd3) begin
              n_d        = n_inc;
              oam_addr_d = {n_inc, 2'b00};
              if (n_q == 6'd63)         state_d = StDone;
              else if (wp_inc == 6'd32) state_d = StOvfScan;
              else                      state_d = StScanY;
            end else begin
              bc_d       = bc_q + 2'd1;
              oam_addr_d = {n_q, bc_q + 2'd1};
            end
          end
          StOvfScan: begin
            if (in_range) begin
              ovf_d   = 1'b1;
              state_d = StDone;
            end else begin
              n_d        = n_inc;
              oam_addr_d = {n_inc, 2'b00};
              if (n_q == 6'd63) state_d = StDone;
            end
          end
          default: ;
        endcase
      end
    end else begin
      state_d = StIdle;
    end

    // Registered, so the address reads 0 throughout dots 257-320.
    if (active && cycle >= 9'd256 && cycle <= 9'd319) begin
      oam_addr_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wp_q       <= 6'd0;
      n_q        <= 6'd0;
      bc_q       <= 2'd0;
      oam_addr_q <= 8'd0;
      ovf_q      <= 1'b0;
      sp0_next_q <= 1'b0;
      sp0_line_q <= 1'b0;
      for (int i = 0; i < 32; i++) sec_q[i] <= 8'hFF;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      n_q        <= n_d;
      bc_q       <= bc_d;
      oam_addr_q <= oam_addr_d;
      ovf_q      <= ovf_d;
      sp0_next_q <= sp0_next_d;
      sp0_line_q <= sp0_line_d;
      if (sec_we) sec_q[sec_wa] <= sec_wd;
    end
  end

  // Fetch-side slot view
  logic [2:0] slot;
  logic [7:0] f_y, f_tile, f_at, f_x;
  logic [3:0] row;

  assign slot   = cycle[5:3];
  assign f_y    = sec_q[{slot, 2'b00}];
  assign f_tile = sec_q[{slot, 2'b01}];
  assign f_at   = sec_q[{slot, 2'b10}];
  assign f_x    = sec_q[{slot, 2'b11}];

  always_comb begin
    sp_inscan = (f_y != 8'hFF);
    sp_tile   = f_tile;
    sp_at     = f_at;
    sp_x      = f_x;
    // Only the low four bits of scanline - y matter for the row.
    row       = scanline[3:0] - f_y[3:0];
    if (f_at[7]) row = (sp_size16 ? 4'd15 : 4'd7) - row;
    if (!sp_inscan) begin
      sp_tile = 8'hFF;
      sp_at   = 8'hFF;
      sp_x    = 8'hFF;
      row     = 4'd0;
    end
    if (sp_size16) sp_pat_addr = {sp_tile[0], sp_tile[7:1], row[3], 1'b0, row[2:0]};
    else           sp_pat_addr = {sp_pt_sel, sp_tile, 1'b0, row[2:0]};
  end

  assign oam_addr    = oam_addr_q;
  assign overflow    = ovf_q;
  assign sp0_in_line = sp0_line_q;

endmodule

// File: tb/tb_sprite_eval.sv
// Directed bench for sprite_eval: a synchronous-read primary OAM model and hand-computed
// expectations for slot contents, pattern addresses, sprite-0 and overflow flags.
module tb_sprite_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  cycle;
  logic [8:0]  scanline;
  logic        rendering;
  logic        sp_size16;
  logic        sp_pt_sel;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic [7:0]  sp_tile;
  logic [7:0]  sp_at;
  logic [7:0]  sp_x;
  logic [12:0] sp_pat_addr;
  logic        sp_inscan;
  logic        sp0_in_line;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] oam_mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) oam_data <= oam_mem[oam_addr];

  sprite_eval dut (
    .clk         (clk),
    .rst         (rst),
    .cycle       (cycle),
    .scanline    (scanline),
    .rendering   (rendering),
    .sp_size16   (sp_size16),
    .sp_pt_sel   (sp_pt_sel),
    .oam_addr    (oam_addr),
    .oam_data    (oam_data),
    .sp_tile     (sp_tile),
    .sp_at       (sp_at),
    .sp_x        (sp_x),
    .sp_pat_addr (sp_pat_addr),
    .sp_inscan   (sp_inscan),
    .sp0_in_line (sp0_in_line),
    .overflow    (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'hFF;
  endtask

  task automatic set_sprite(input int n, input logic [7:0] y, input logic [7:0] tile,
                            input logic [7:0] at, input logic [7:0] x);
    oam_mem[4*n]   = y;
    oam_mem[4*n+1] = tile;
    oam_mem[4*n+2] = at;
    oam_mem[4*n+3] = x;
  endtask

  task automatic start_line(input int sl);
    @(posedge clk);
    #1;
    scanline = 9'(sl);
    cycle    = 9'd0;
    #1;
  endtask

  task automatic advance_to(input int c);
    while (int'(cycle) < c) begin
      @(posedge clk);
      #1;
      cycle = cycle + 9'd1;
    end
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    cycle     = 9'd0;
    scanline  = 9'd0;
    rendering = 1'b0;
    sp_size16 = 1'b0;
    sp_pt_sel = 1'b0;
    clear_oam();
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_oam_addr", 32'(oam_addr), 'h0);
    check_eq("rst_overflow", 32'(overflow), 'h0);
    check_eq("rst_sp0", 32'(sp0_in_line), 'h0);
    check_eq("rst_inscan", 32'(sp_inscan), 'h0);
    check_eq("rst_tile", 32'(sp_tile), 'hFF);
    check_eq("rst_at", 32'(sp_at), 'hFF);
    check_eq("rst_x", 32'(sp_x), 'hFF);
    rst       = 1'b0;
    rendering = 1'b1;

    // All Y=0xFF on scanline 10
    start_line(10);
    advance_to(65);
    check_eq("t1_addr65", 32'(oam_addr), 'h0);
    advance_to(67);
    check_eq("t1_addr67", 32'(oam_addr), 'h4);
    for (int s = 0; s < 8; s++) begin
      advance_to(258 + 8 * s);
      check_eq($sformatf("t1_inscan_s%0d", s), 32'(sp_inscan), 'h0);
    end
    check_eq("t1_overflow", 32'(overflow), 'h0);
    check_eq("t1_sp0", 32'(sp0_in_line), 'h0);

    // Sprite 0, 8x8, pattern table 1
    clear_oam();
    set_sprite(0, 8'd10, 8'h42, 8'h00, 8'h30);
    sp_pt_sel = 1'b1;
    start_line(13);
    advance_to(260);
    check_eq("t2_tile", 32'(sp_tile), 'h42);
    check_eq("t2_x", 32'(sp_x), 'h30);
    check_eq("t2_at", 32'(sp_at), 'h00);
    check_eq("t2_pat", 32'(sp_pat_addr), 'h1423);
    check_eq("t2_inscan", 32'(sp_inscan), 'h1);
    check_eq("t2_sp0", 32'(sp0_in_line), 'h1);
    check_eq("t2_addr_fetch", 32'(oam_addr), 'h0);
    advance_to(266);
    check_eq("t2_slot1_inscan", 32'(sp_inscan), 'h0);
    check_eq("t2_slot1_at", 32'(sp_at), 'hFF);

    // Sprite 5, 8x16, vertical flip
    clear_oam();
    set_sprite(5, 8'd20, 8'h43, 8'h80, 8'h77);
    sp_size16 = 1'b1;
    start_line(22);
    advance_to(260);
    check_eq("t3_tile", 32'(sp_tile), 'h43);
    check_eq("t3_at", 32'(sp_at), 'h80);
    check_eq("t3_x", 32'(sp_x), 'h77);
    check_eq("t3_pat", 32'(sp_pat_addr), 'h1435);
    check_eq("t3_sp0", 32'(sp0_in_line), 'h0);

    // Nine sprites in range: overflow
    clear_oam();
    sp_size16 = 1'b0;
    sp_pt_sel = 1'b0;
    for (int i = 0; i < 9; i++) set_sprite(i, 8'd50, 8'(8'h10 + i), 8'(i), 8'(8 * i));
    start_line(52);
    advance_to(257);
    check_eq("t4_overflow", 32'(overflow), 'h1);
    for (int s = 0; s < 8; s++) begin
      advance_to(258 + 8 * s);
      check_eq($sformatf("t4_tile_s%0d", s), 32'(sp_tile), 32'(8'h10 + s));
      check_eq($sformatf("t4_x_s%0d", s), 32'(sp_x), 32'(8 * s));
      check_eq($sformatf("t4_inscan_s%0d", s), 32'(sp_inscan), 'h1);
      if (s == 3) check_eq("t4_pat_s3", 32'(sp_pat_addr), 'h132);
    end
    check_eq("t4_sp0", 32'(sp0_in_line), 'h1);
    start_line(240);
    advance_to(10);
    check_eq("t4_ovf_vblank", 32'(overflow), 'h1);
    start_line(261);
    advance_to(1);
    check_eq("t4_ovf_261c1", 32'(overflow), 'h1);
    advance_to(2);
    check_eq("t4_ovf_cleared", 32'(overflow), 'h0);

    // Eight in range, ninth out of range: no overflow
    clear_oam();
    for (int i = 0; i < 8; i++) set_sprite(i, 8'd50, 8'(8'h10 + i), 8'h00, 8'(8 * i));
    set_sprite(8, 8'd200, 8'h99, 8'h00, 8'h00);
    start_line(52);
    advance_to(300);
    check_eq("t5_overflow", 32'(overflow), 'h0);
    check_eq("t5_tile_s5", 32'(sp_tile), 'h15);

    // Rendering dropped at dot 100 freezes oam_addr and secondary writes
    clear_oam();
    set_sprite(20, 8'd100, 8'h55, 8'h00, 8'h11);
    start_line(101);
    advance_to(99);
    check_eq("t6_addr99", 32'(oam_addr), 'h44);
    advance_to(100);
    rendering = 1'b0;
    advance_to(150);
    check_eq("t6_addr150", 32'(oam_addr), 'h44);
    advance_to(258);
    check_eq("t6_addr258", 32'(oam_addr), 'h44);
    check_eq("t6_inscan", 32'(sp_inscan), 'h0);
    check_eq("t6_sp0", 32'(sp0_in_line), 'h0);
    rendering = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_eval.md
# sprite_eval

Per-scanline sprite evaluation stage of the PPU. During cycles 1–256 of each visible scanline it clears a 32-byte secondary OAM, scans the 64-entry primary OAM for sprites in range of the next line, copies up to eight of them, and flags sprite 0 presence and sprite overflow. During cycles 257–320 it presents one secondary-OAM slot per 8-cycle fetch window (slot = cycle[5:3]) to the fetch logic that loads the eight per-sprite pixel units.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cycle  in  9  PPU dot 0–340
- scanline  in  9  0–239 visible, 240–260 idle/vblank, 261 pre-render
- rendering  in  1  background or sprite rendering enabled
- sp_size16  in  1  8x16 sprite mode
- sp_pt_sel  in  1  pattern table select for 8x8 sprites
- oam_addr  out  8  primary OAM read address (registered)
- oam_data  in  8  primary OAM read data, valid the cycle after oam_addr
- sp_tile  out  8  tile byte of current slot
- sp_at  out  8  attribute byte of current slot
- sp_x  out  8  X byte of current slot
- sp_pat_addr  out  13  pattern address of current slot, plane bit[3]=0
- sp_inscan  out  1  current slot holds a real sprite
- sp0_in_line  out  1  sprite 0 occupies slot 0 for the line being drawn
- overflow  out  1  sprite overflow status

## Operation
- Active only when rendering=1 and scanline ≤ 239; otherwise FSM forced to IDLE, no secondary-OAM writes, oam_addr held.
- FSM states: IDLE, CLEAR, SCAN_Y, COPY, OVF_SCAN, DONE.
- CLEAR (cycles 1–64): on each even cycle write 0xFF to secondary byte (cycle−1)>>1. Secondary write pointer wp (6-bit) and sprite index n (6-bit) reset to 0 at cycle 64.
- Evaluation (cycles 65–256): two cycles per step; odd cycle presents address, even cycle consumes oam_data.
- SCAN_Y: oam_addr={n,2'b00}. diff = scanline − {1'b0,y} (9-bit unsigned); in range iff diff < (sp_size16 ? 16 : 8). Y always written to secondary[wp]. In range: wp+1, → COPY for bytes 1..3; if n==0 set sp0_next. Not in range: n+1.
- COPY: copy bytes 1,2,3 to secondary[wp..wp+2]; after byte 3, n+1, → SCAN_Y, or OVF_SCAN if wp==32.
- OVF_SCAN: read Y of each remaining sprite; first in-range one sets overflow and → DONE. No hardware diagonal-scan bug modelled.
- n wrapping 63→0 in any state → DONE; DONE idles until cycle 256.
- Cycle 257: sp0_in_line ← sp0_next, sp0_next ← 0; holds until next 257. oam_addr driven 0 during 257–320.
- Fetch (257–320): slot s=cycle[5:3] selects secondary bytes 4s..4s+3. sp_inscan = (y≠0xFF). row = (scanline − y)[3:0]; if sp_at[7] row = (sp_size16?15:7) − row. Address: 8x8 {sp_pt_sel, tile, 0, row[2:0]}; 8x16 {tile[0], tile[7:1], row[3], 0, row[2:0]}. Empty slot: sp_inscan=0, sp_at=0xFF, sp_x=0xFF, address from tile 0xFF row 0; downstream zeroes pattern.
- overflow cleared at cycle 1 of scanline 261.

## Timing
- Reset: oam_addr=0, overflow=0, sp0_in_line=0, sp0_next=0, all secondary bytes 0xFF, FSM IDLE; so sp_inscan=0, sp_tile=sp_at=sp_x=0xFF.
- Slot outputs combinational from secondary OAM and cycle; stable for all eight cycles of each window.
- Secondary writes are single-cycle on even cycles; evaluation ends by cycle 256 at worst case (64 Y steps + 8×3 copies = 88 steps ≤ 96).
- rendering deasserted mid-line: FSM → IDLE next cycle; partially filled secondary OAM retained; overflow retained.
- rst mid-evaluation: reset values next cycle, resume at next cycle-1 boundary.

## Test plan
- All Y=0xFF, scanline 10 → sp_inscan=0 all slots 257–320, overflow=0, sp0_in_line=0.
- Sprite 0 Y=10, tile 0x42, at 0x00, x 0x30, sp_pt_sel=1, scanline 13 → slot 0: tile 0x42, x 0x30, sp_pat_addr 0x1423, sp0_in_line=1 from cycle 257.
- Sprite 5 Y=20, at 0x80, sp_size16=1, tile 0x43, scanline 22 → row 13; sp_pat_addr 0x1435.
- Nine sprites Y=50, scanline 52 → slots 0–7 = sprites 0–7, overflow=1 at end of eval; cleared at scanline 261 cycle 1.
- Eight sprites Y=50, ninth Y=200, scanline 52 → overflow stays 0.
- rendering=0 from cycle 100 → no secondary writes after 100, oam_addr frozen.
